// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles decode control, the instruction BRAM port and the IF/ID-facing outputs
interface fetch_unit_if #(parameter int ADDR_W = 14);
    logic              stall;
    logic              redirect;
    logic [63:0]       redirect_pc;
    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic              inst_valid;
    logic [31:0]       inst;
    logic [63:0]       inst_pc;
    logic [63:0]       fetch_pc;
    logic              misalign_err;
    modport master (
        input  stall, redirect, redirect_pc, imem_data,
        output imem_en, imem_addr, inst_valid, inst, inst_pc, fetch_pc, misalign_err
    );
    modport slave (
        output stall, redirect, redirect_pc, imem_data,
        input  imem_en, imem_addr, inst_valid, inst, inst_pc, fetch_pc, misalign_err
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: drives a 1-cycle BRAM, buffers {word, pc} in a credit-limited prefetch queue
// and presents the head to decode; redirect squashes the queue and any returning word.
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          DEPTH    = 4,
    parameter int          ADDR_W   = 14
) (
    input logic          clk,
    input logic          reset,
    fetch_unit_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    typedef enum logic {BOOT, RUN} state_t;
    state_t      state, state_nxt;
    logic [31:0] q_inst [DEPTH];
    logic [63:0] q_pc [DEPTH];
    logic [PW-1:0] head, tail;
    logic [PW:0]   count;
    logic          inflight, misalign, valid, issue, req, push, pop;
    logic [63:0]   tag_pc, fetch_pc, req_pc;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= BOOT;
        else state <= state_nxt;
    end
    // Credits count the in-flight word so a push can never find the queue full
    always_comb begin
        state_nxt = RUN;
        valid     = count != '0;
        issue     = (state == RUN) && ((count + (PW+1)'(inflight)) < (PW+1)'(DEPTH));
        req       = (state == RUN) && (issue || bus.redirect);
        req_pc    = bus.redirect ? bus.redirect_pc : fetch_pc;
        push      = inflight && !bus.redirect;
        pop       = valid && !bus.stall && !bus.redirect;
    end
    assign bus.imem_en      = req;
    assign bus.imem_addr    = req_pc[ADDR_W+1:2];
    assign bus.inst_valid   = valid;
    assign bus.inst         = valid ? q_inst[head] : 32'h0000_0013;
    assign bus.inst_pc      = valid ? q_pc[head] : 64'h0;
    assign bus.fetch_pc     = fetch_pc;
    assign bus.misalign_err = misalign;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            inflight <= 1'b0;
            tag_pc   <= '0;
            fetch_pc <= RESET_PC;
            misalign <= 1'b0;
        end else begin
            inflight <= req;
            if (req) begin
                tag_pc   <= req_pc;
                fetch_pc <= req_pc + 64'd4;
            end else if (bus.redirect) begin
                fetch_pc <= bus.redirect_pc;
            end
            if (bus.redirect && bus.redirect_pc[1:0] != 2'b00) misalign <= 1'b1;
            if (bus.redirect) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                head  <= head + PW'(pop);
                tail  <= tail + PW'(push);
                count <= count + (PW+1)'(push) - (PW+1)'(pop);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            q_inst[tail] <= bus.imem_data;
            q_pc[tail]   <= tag_pc;
        end
    end
endmodule
